// File: rtl/jtag_host_pkg.sv
// Shared types and TMS sequencing constants for the jtag_host JTAG initiator.
// Patterns are stored LSB first: bit 0 is the TMS value of the first TCK.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_RESET   = 2'd0,
        OP_SCAN_IR = 2'd1,
        OP_SCAN_DR = 2'd2,
        OP_RSVD    = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_DONE
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [15:0] data;
    } cmd_t;

    localparam logic [4:0] HDR_LEN_RST  = 5'd5;
    localparam logic [4:0] HDR_LEN_IR   = 5'd4;
    localparam logic [4:0] HDR_LEN_DR   = 5'd3;
    localparam logic [4:0] TRL_LEN_RST  = 5'd1;
    localparam logic [4:0] TRL_LEN_SCAN = 5'd2;

    localparam logic [4:0] HDR_PAT_RST  = 5'b11111;
    localparam logic [4:0] HDR_PAT_IR   = 5'b00011;
    localparam logic [4:0] HDR_PAT_DR   = 5'b00001;
    localparam logic [1:0] TRL_PAT_RST  = 2'b00;
    localparam logic [1:0] TRL_PAT_SCAN = 2'b01;

    function automatic logic [4:0] hdr_len(op_e op);
        case (op)
            OP_RESET:   hdr_len = HDR_LEN_RST;
            OP_SCAN_IR: hdr_len = HDR_LEN_IR;
            default:    hdr_len = HDR_LEN_DR;
        endcase
    endfunction

    function automatic logic [4:0] hdr_pat(op_e op);
        case (op)
            OP_RESET:   hdr_pat = HDR_PAT_RST;
            OP_SCAN_IR: hdr_pat = HDR_PAT_IR;
            default:    hdr_pat = HDR_PAT_DR;
        endcase
    endfunction

    function automatic logic [4:0] trl_len(op_e op);
        trl_len = (op == OP_RESET) ? TRL_LEN_RST : TRL_LEN_SCAN;
    endfunction

    function automatic logic [1:0] trl_pat(op_e op);
        trl_pat = (op == OP_RESET) ? TRL_PAT_RST : TRL_PAT_SCAN;
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: each bit is TCK_HALF clk low then TCK_HALF clk high.
// Both strobes mark the last high clk; the edge ending it samples tdo and drops tck.
module jtag_tck_gen #(
    parameter int TCK_HALF = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic sample_stb
);
    localparam int CW = $clog2(2 * TCK_HALF);
    localparam logic [CW-1:0] LAST = CW'(2 * TCK_HALF - 1);
    localparam logic [CW-1:0] HALF = CW'(TCK_HALF);

    logic [CW-1:0] cnt, cnt_n;

    always_comb cnt_n = (cnt == LAST) ? '0 : cnt + CW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= cnt_n;
            tck <= (cnt_n >= HALF);
        end
    end

    assign sample_stb = en && (cnt == LAST);
    assign fall_stb   = en && (cnt == LAST);
endmodule

// File: rtl/jtag_host.sv
// Host-side JTAG driver: one RESET / SCAN_IR / SCAN_DR command at a time, TDO returned on rsp.
// Optional JTAG_HOST_LOOPBACK_EN adds loop_en, which samples the driven tdi instead of the tdo pin.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int TCK_HALF = 4,
    parameter int IR_LEN   = 8,
    parameter int DR_LEN   = 16
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef JTAG_HOST_LOOPBACK_EN
    input  logic        loop_en,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    input  logic        tdo
);
    localparam logic [4:0] IR_L = 5'(IR_LEN);
    localparam logic [4:0] DR_L = 5'(DR_LEN);

    state_e      state, state_n;
    cmd_t        cmd, cmd_n;
    logic [4:0]  idx, idx_n;
    logic [15:0] cap, cap_n;
    logic        tms_n, tdi_n;
    logic        rsp_valid_n, rsp_err_n;
    logic [15:0] rsp_data_n;
    logic        en, fall_stb, sample_stb, tdo_s;
    logic [4:0]  len, hlen, tlen, hpat, new_pat;
    logic [1:0]  tpat;

    jtag_tck_gen #(.TCK_HALF(TCK_HALF)) u_tck (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .tck        (tck),
        .fall_stb   (fall_stb),
        .sample_stb (sample_stb)
    );

    assign en        = (state == ST_PRE) || (state == ST_SHIFT) || (state == ST_POST);
    assign cmd_ready = (state == ST_IDLE);
    assign len       = (cmd.op == OP_SCAN_IR) ? IR_L : DR_L;
    assign hlen      = hdr_len(cmd.op);
    assign hpat      = hdr_pat(cmd.op);
    assign tlen      = trl_len(cmd.op);
    assign tpat      = trl_pat(cmd.op);

`ifdef JTAG_HOST_LOOPBACK_EN
    assign tdo_s = loop_en ? tdi : tdo;
`else
    assign tdo_s = tdo;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            idx       <= '0;
            cap       <= '0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cmd       <= cmd_n;
            idx       <= idx_n;
            cap       <= cap_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_data  <= rsp_data_n;
        end
    end

    // tms/tdi for the next bit are loaded on the edge that drops tck (fall_stb).
    always_comb begin
        state_n     = state;
        cmd_n       = cmd;
        idx_n       = idx;
        cap_n       = cap;
        tms_n       = tms;
        tdi_n       = tdi;
        rsp_valid_n = 1'b0;
        rsp_err_n   = rsp_err;
        rsp_data_n  = rsp_data;
        new_pat     = hdr_pat(op_e'(cmd_op));
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_n.op   = op_e'(cmd_op);
                    cmd_n.data = cmd_data;
                    idx_n      = '0;
                    cap_n      = '0;
                    if (op_e'(cmd_op) == OP_RSVD) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_PRE;
                        tms_n   = new_pat[0];
                        tdi_n   = 1'b0;
                    end
                end
            end
            ST_PRE: begin
                if (fall_stb) begin
                    if (idx == hlen - 5'd1) begin
                        idx_n = '0;
                        if (cmd.op == OP_RESET) begin
                            state_n = ST_POST;
                            tms_n   = tpat[0];
                            tdi_n   = 1'b0;
                        end else begin
                            state_n = ST_SHIFT;
                            tms_n   = (len == 5'd1);
                            tdi_n   = cmd.data[0];
                        end
                    end else begin
                        idx_n = idx + 5'd1;
                        tms_n = hpat[idx_n[2:0]];
                    end
                end
            end
            ST_SHIFT: begin
                if (sample_stb)
                    cap_n = {tdo_s, cap[15:1]};
                if (fall_stb) begin
                    if (idx == len - 5'd1) begin
                        state_n = ST_POST;
                        idx_n   = '0;
                        tms_n   = tpat[0];
                        tdi_n   = 1'b0;
                    end else begin
                        idx_n = idx + 5'd1;
                        tms_n = (idx_n == len - 5'd1);
                        tdi_n = cmd.data[idx_n[3:0]];
                    end
                end
            end
            ST_POST: begin
                if (fall_stb) begin
                    if (idx == tlen - 5'd1) begin
                        state_n = ST_DONE;
                    end else begin
                        idx_n = idx + 5'd1;
                        tms_n = tpat[idx_n[0]];
                    end
                end
            end
            ST_DONE: begin
                // cap is zero for RESET and reserved ops, so the shift is harmless there
                state_n     = ST_IDLE;
                rsp_valid_n = 1'b1;
                rsp_err_n   = (cmd.op == OP_RSVD);
                rsp_data_n  = cap >> (5'd16 - len);
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_jtag_host.sv
// Scoreboard bench for jtag_host: random commands, TCK-level recording of tms/tdi, target tdo model.
module tb_jtag_host;
    localparam int TCK_HALF = 4;
    localparam int IR_LEN   = 8;
    localparam int DR_LEN   = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        loop_en_v;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        tck, tms, tdi, tdo;

    jtag_host #(.TCK_HALF(TCK_HALF), .IR_LEN(IR_LEN), .DR_LEN(DR_LEN)) dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef JTAG_HOST_LOOPBACK_EN
        .loop_en   (loop_en_v),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] d;
        logic [15:0] tw;
        int          acc;
        int          start;
        logic        lp;
    } exp_t;

    exp_t exp_q[$];
    bit   rec_tms[$];
    bit   rec_tdi[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0, last_rsp = 0;
    int   cur_start = 0;
    logic [1:0]  cur_op = 2'd0;
    logic [15:0] cur_tdo = 16'd0;
    logic [15:0] next_tdo = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected TCK stream from the JTAG rules: tms/tdi per TCK, returns TCK count.
    function automatic int model_seq(input logic [1:0] op, input logic [15:0] d,
                                     output logic [63:0] tms_w, output logic [63:0] tdi_w);
        int k = 0;
        int ln;
        tms_w = '0;
        tdi_w = '0;
        if (op == 2'd0) begin
            for (int i = 0; i < 5; i++) begin tms_w[k] = 1'b1; k++; end
            tms_w[k] = 1'b0; k++;
        end else if (op == 2'd1 || op == 2'd2) begin
            tms_w[k] = 1'b1; k++;
            if (op == 2'd1) begin tms_w[k] = 1'b1; k++; end
            tms_w[k] = 1'b0; k++;
            tms_w[k] = 1'b0; k++;
            ln = (op == 2'd1) ? IR_LEN : DR_LEN;
            for (int i = 0; i < ln; i++) begin
                tms_w[k] = (i == ln - 1);
                tdi_w[k] = d[i];
                k++;
            end
            tms_w[k] = 1'b1; k++;
            tms_w[k] = 1'b0; k++;
        end
        return k;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Accept tracker: pushes the expected outcome for every accepted command.
    always @(negedge clk) begin
        if (rstn && cmd_valid && cmd_ready) begin
            exp_t e;
            e.op = cmd_op; e.d = cmd_data; e.tw = next_tdo;
            e.acc = cyc + 1; e.start = rec_tms.size(); e.lp = loop_en_v;
            exp_q.push_back(e);
            cur_start = rec_tms.size();
            cur_op    = cmd_op;
            cur_tdo   = next_tdo;
            last_acc  = cyc + 1;
        end
    end

    // Target model: record tms/tdi on each rising TCK, present tdo for shift bits.
    int r_idx, r_hl, r_ln;
    always @(posedge tck) begin
        r_idx = rec_tms.size() - cur_start;
        rec_tms.push_back(tms);
        rec_tdi.push_back(tdi);
        r_hl = (cur_op == 2'd1) ? 4 : 3;
        r_ln = (cur_op == 2'd1) ? IR_LEN : DR_LEN;
        if ((cur_op == 2'd1 || cur_op == 2'd2) && r_idx >= r_hl && r_idx < r_hl + r_ln)
            tdo = cur_tdo[r_idx - r_hl];
        else
            tdo = 1'($urandom_range(0, 1));
    end

    // Monitor: pops and compares on every response strobe.
    exp_t        m_e;
    int          m_n, m_cnt, m_ln;
    logic [63:0] m_tms, m_tdi, m_at, m_ad;
    logic [15:0] m_d;
    always @(negedge clk) begin
        if (rstn && rsp_valid) begin
            last_rsp = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                m_e   = exp_q.pop_front();
                m_n   = model_seq(m_e.op, m_e.d, m_tms, m_tdi);
                m_cnt = rec_tms.size() - m_e.start;
                m_at  = '0;
                m_ad  = '0;
                for (int i = 0; i < m_cnt && i < 64; i++) begin
                    m_at[i] = rec_tms[m_e.start + i];
                    m_ad[i] = rec_tdi[m_e.start + i];
                end
                m_d  = '0;
                m_ln = (m_e.op == 2'd1) ? IR_LEN : DR_LEN;
                if (m_e.op == 2'd1 || m_e.op == 2'd2)
                    for (int i = 0; i < m_ln; i++) m_d[i] = m_e.lp ? m_e.d[i] : m_e.tw[i];
                check("tck_count", 64'(m_cnt), 64'(m_n));
                check("tms_seq", m_at, m_tms);
                check("tdi_seq", m_ad, m_tdi);
                check("rsp_data", 64'(rsp_data), 64'(m_d));
                check("rsp_err", 64'(rsp_err), 64'(m_e.op == 2'd3));
                check("latency", 64'(cyc - m_e.acc), 64'(m_n * 2 * TCK_HALF + 1));
                check("ready_in_rsp", 64'(cmd_ready), 64'd1);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [15:0] tw);
        int g = 0;
        @(posedge clk); #1;
        next_tdo  = tw;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        while (!cmd_ready && g < 1000) begin @(negedge clk); g++; end
        if (!cmd_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: got no cmd_ready, expected accept");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !cmd_ready) && g < 2000) begin @(negedge clk); g++; end
        if (g >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: got busy, expected idle");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int a_rsp;
        rstn = 1'b0; loop_en_v = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; tdo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({tck, tms, tdi, cmd_ready, rsp_valid, rsp_data, rsp_err}),
              64'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0}));
        @(negedge clk); #2; rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tms_after_reset", 64'(tms), 64'd1);

        issue(2'd0, 16'h1234, 16'hFFFF);
        wait_idle();
        check("idle_tms_after_cmd", 64'(tms), 64'd0);

        issue(2'd2, 16'hA5C3, 16'h1234);
        wait_idle();
        issue(2'd1, 16'hFF3C, 16'($urandom));
        wait_idle();
        issue(2'd3, 16'hBEEF, 16'h0);
        wait_idle();

        // Back-to-back: second command held valid while busy.
        issue(2'd2, 16'($urandom), 16'($urandom));
        issue(2'd1, 16'($urandom), 16'($urandom));
        a_rsp = last_rsp;
        check("b2b_accept_in_rsp_cycle", 64'(last_acc), 64'(a_rsp + 1));
        wait_idle();

        // Abort mid SCAN_DR at TCK 10.
        issue(2'd2, 16'($urandom), 16'($urandom));
        g = 0;
        while ((rec_tms.size() - cur_start) < 10 && g < 1000) begin @(negedge clk); g++; end
        if (g >= 1000) begin
            n_chk++; n_fail++;
            $display("FAIL abort_wait: got no TCK 10, expected it");
        end
        @(negedge clk); #2; rstn = 1'b0; #1;
        check("abort_tck", 64'(tck), 64'd0);
        check("abort_tms", 64'(tms), 64'd1);
        check("abort_ready", 64'(cmd_ready), 64'd1);
        check("abort_rsp", 64'(rsp_valid), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2; rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("post_abort_tms", 64'(tms), 64'd1);
        issue(2'd0, 16'h0, 16'($urandom));
        wait_idle();

`ifdef JTAG_HOST_LOOPBACK_EN
        loop_en_v = 1'b1;
        issue(2'd2, 16'hBEEF, 16'($urandom));
        wait_idle();
        loop_en_v = 1'b0;
`endif

        for (int i = 0; i < 16; i++) begin
            issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                wait_idle();
                repeat ($urandom_range(0, 5)) @(posedge clk);
            end
        end
        wait_idle();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
